heater_pwm_ctrl: RTL

Heater core controller that sits directly downstream of the AXI4-Lite heater register slave. It consumes the four slave registers (control, duty, period, run length) and drives a bank of heater cell enables with a PWM waveform. It adds an optional staggered soft-start, a period-count run timer with automatic stop, and a sticky thermal-trip shutdown. Status outputs feed back into the slave's read-only register path.

---
 rtl/heater_pkg.sv | 22 ++
 rtl/heater_pwm_gen.sv | 68 ++++++
 rtl/heater_pwm_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/heater_pkg.sv
// Shared types and constants for the heater PWM controller.
// Holds the FSM state enum, control bit index and saturation helper.
package heater_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAMP,
    ST_RUN,
    ST_DONE,
    ST_FAULT
  } state_e;

  localparam int CTRL_EN_BIT = 0;
  localparam int DEF_N_CELLS = 64;
  localparam int DEF_RAMP_STEP = 16;
  localparam logic [31:0] ELAPSED_MAX = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == ELAPSED_MAX) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/heater_pwm_gen.sv
// PWM period counter with shadowed duty/period and a saturating
// count of completed periods.
module heater_pwm_gen
  import heater_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [31:0] duty_i,
  input  logic [31:0] period_i,
  output logic        pwm_o,
  output logic        wrap_o,
  output logic [31:0] elapsed_o
);

  logic [31:0] cnt_q, cnt_d;
  logic [31:0] duty_q, duty_d;
  logic [31:0] per_q, per_d;
  logic [31:0] el_q, el_d;
  logic [31:0] last;
  logic        wrap;

  // A zero period behaves as a one-cycle period.
  assign last = (per_q == 32'd0) ? 32'd0 : per_q - 32'd1;
  assign wrap = en_i && (cnt_q == last);

  assign pwm_o = cnt_q < duty_q;
  assign wrap_o = wrap;
  assign elapsed_o = el_q;

  // Counter advance; shadows reload only on clear or period wrap.
  always_comb begin
    cnt_d = cnt_q;
    duty_d = duty_q;
    per_d = per_q;
    el_d = el_q;
    if (clr_i) begin
      cnt_d = 32'd0;
      duty_d = duty_i;
      per_d = period_i;
      el_d = 32'd0;
    end else if (wrap) begin
      cnt_d = 32'd0;
      duty_d = duty_i;
      per_d = period_i;
      el_d = sat_inc(el_q);
    end else if (en_i) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // State registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= 32'd0;
      duty_q <= 32'd0;
      per_q <= 32'd0;
      el_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
      duty_q <= duty_d;
      per_q <= per_d;
      el_q <= el_d;
    end
  end

endmodule

// File: rtl/heater_pwm_ctrl.sv
// Heater cell PWM controller: run FSM, soft-start mask, trip shutdown.
// Define HEATER_RAMP_EN to build the staggered soft-start RAMP state.
module heater_pwm_ctrl
  import heater_pkg::*;
#(
  parameter int N_CELLS = DEF_N_CELLS,
  parameter int RAMP_STEP = DEF_RAMP_STEP
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [31:0]        reg_ctrl,
  input  logic [31:0]        reg_duty,
  input  logic [31:0]        reg_period,
  input  logic [31:0]        reg_runtime,
  input  logic               therm_trip,
  output logic [N_CELLS-1:0] heater_en,
  output logic               busy,
  output logic               done,
  output logic               fault,
  output logic [31:0]        elapsed
);

  localparam logic [N_CELLS-1:0] MASK_ONE = N_CELLS'(1);
  localparam logic [N_CELLS-1:0] MASK_ALL = '1;

  state_e state_q, state_d;
  logic [N_CELLS-1:0] mask_q, mask_d;
  logic [N_CELLS-1:0] heat_q, heat_d;
  logic en_prev_q;
  logic en, start, clr, run_q, run_d;
  logic pwm, wrap, hit;
  logic [31:0] el;
  logic unused_ctrl;

  assign unused_ctrl = ^{reg_ctrl[31:1]};

`ifdef HEATER_RAMP_EN
  localparam int RW = (RAMP_STEP > 1) ? $clog2(RAMP_STEP) : 1;
  localparam logic [RW-1:0] RAMP_LAST = RW'(RAMP_STEP - 1);
  logic [RW-1:0] ramp_q, ramp_d;
`else
  logic unused_step;
  assign unused_step = RAMP_STEP > 0;
`endif

  assign en = reg_ctrl[CTRL_EN_BIT];
  assign start = en && !en_prev_q;
  assign run_q = (state_q == ST_RAMP) || (state_q == ST_RUN);
  assign run_d = (state_d == ST_RAMP) || (state_d == ST_RUN);
  assign hit = wrap && (reg_runtime != 32'd0)
            && (sat_inc(el) >= reg_runtime);

  heater_pwm_gen u_gen (
    .clock     (clock),
    .reset     (reset),
    .clr_i     (clr),
    .en_i      (run_q),
    .duty_i    (reg_duty),
    .period_i  (reg_period),
    .pwm_o     (pwm),
    .wrap_o    (wrap),
    .elapsed_o (el)
  );

  // Next state, mask and ramp progress in priority order.
  always_comb begin
    state_d = state_q;
    mask_d = mask_q;
    clr = 1'b0;
`ifdef HEATER_RAMP_EN
    ramp_d = ramp_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (therm_trip) begin
            state_d = ST_FAULT;
          end else begin
            clr = 1'b1;
`ifdef HEATER_RAMP_EN
            mask_d = MASK_ONE;
            ramp_d = '0;
            state_d = ST_RAMP;
`else
            mask_d = MASK_ALL;
            state_d = ST_RUN;
`endif
          end
        end
      end
`ifdef HEATER_RAMP_EN
      ST_RAMP: begin
        if (therm_trip) begin
          state_d = ST_FAULT;
        end else if (!en) begin
          state_d = ST_IDLE;
        end else if (hit) begin
          state_d = ST_DONE;
        end else if (ramp_q == RAMP_LAST) begin
          ramp_d = '0;
          if (mask_q == MASK_ALL) begin
            state_d = ST_RUN;
          end else begin
            mask_d = (mask_q << 1) | MASK_ONE;
          end
        end else begin
          ramp_d = ramp_q + RW'(1);
        end
      end
`endif
      ST_RUN: begin
        if (therm_trip) state_d = ST_FAULT;
        else if (!en) state_d = ST_IDLE;
        else if (hit) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (therm_trip) state_d = ST_FAULT;
        else if (!en) state_d = ST_IDLE;
      end
      ST_FAULT: begin
        if (!en && !therm_trip) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Cells only drive while heating now and still heating next cycle.
  always_comb begin
    heat_d = '0;
    if (run_q && run_d) heat_d = mask_q & {N_CELLS{pwm}};
  end

  // State, mask and output registers.
  always_ff @(posedge clock) begin
    en_prev_q <= en;
    if (reset) begin
      state_q <= ST_IDLE;
      mask_q <= '0;
      heat_q <= '0;
`ifdef HEATER_RAMP_EN
      ramp_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      mask_q <= mask_d;
      heat_q <= heat_d;
`ifdef HEATER_RAMP_EN
      ramp_q <= ramp_d;
`endif
    end
  end

  assign heater_en = heat_q;
  assign busy = run_q;
  assign done = state_q == ST_DONE;
  assign fault = state_q == ST_FAULT;
  assign elapsed = el;

endmodule
